// File: rtl/tick_period_meter.sv
// Measures the spacing of tick events and reports it in divider form
// (cycles between events minus 1), with lock and lost-tick detection.
module tick_period_meter #(
    parameter int WIDTH       = 21,
    parameter int SYNC_STAGES = 0,
    parameter int EDGE_MODE   = 0,
    parameter int LOCK_COUNT  = 4,
    parameter int TOLERANCE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             clear,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX     = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]   TOL_W       = (WIDTH+1)'(TOLERANCE);
    localparam logic [3:0]       LOCK_MAX    = 4'(LOCK_COUNT);
    localparam logic [3:0]       LOCK_THRESH = 4'(LOCK_COUNT - 1);

    logic             synced_s;
    logic             prev_r;
    logic             event_s;
    state_t           state_r;
    logic [WIDTH-1:0] cnt_r;
    logic [3:0]       match_cnt_r;
    logic [3:0]       match_next_s;
    logic             have_prev_r;
    logic [WIDTH:0]   diff_s;
    logic             match_s;

    generate
        if (SYNC_STAGES >= 1) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_r;

            // Input synchronizer chain; deliberately untouched by clear.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_r <= '0;
                end else begin
                    sync_r[0] <= tick_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_r[i] <= sync_r[i-1];
                    end
                end
            end

            assign synced_s = sync_r[SYNC_STAGES-1];
        end else begin : g_nosync
            assign synced_s = tick_in;
        end
    endgenerate

    // Previous synced level for rising-edge detection; also ignores clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= synced_s;
        end
    end

    // Event qualification and period comparison against the last measurement.
    always_comb begin
        event_s      = 1'b0;
        diff_s       = '0;
        match_s      = 1'b0;
        match_next_s = 4'd0;
        if (EDGE_MODE == 1) begin
            event_s = synced_s & ~prev_r;
        end else begin
            event_s = synced_s;
        end
        if ({1'b0, cnt_r} >= {1'b0, period}) begin
            diff_s = {1'b0, cnt_r} - {1'b0, period};
        end else begin
            diff_s = {1'b0, period} - {1'b0, cnt_r};
        end
        match_s = (diff_s <= TOL_W);
        if (match_cnt_r >= LOCK_MAX) begin
            match_next_s = LOCK_MAX;
        end else begin
            match_next_s = match_cnt_r + 4'd1;
        end
    end

    // Measurement FSM; lock needs LOCK_COUNT agreeing periods in a row,
    // which is LOCK_COUNT-1 successful comparisons.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            match_cnt_r  <= 4'd0;
            have_prev_r  <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (event_s) begin
                        state_r     <= ST_MEASURE;
                        timeout     <= 1'b0;
                        have_prev_r <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (event_s) begin
                        period       <= cnt_r;
                        period_valid <= 1'b1;
                        cnt_r        <= '0;
                        have_prev_r  <= 1'b1;
                        if (have_prev_r) begin
                            if (match_s) begin
                                match_cnt_r <= match_next_s;
                                if (match_next_s >= LOCK_THRESH) begin
                                    locked <= 1'b1;
                                end
                            end else begin
                                match_cnt_r <= 4'd0;
                                locked      <= 1'b0;
                            end
                        end
                    end else if (cnt_r == CNT_MAX) begin
                        timeout     <= 1'b1;
                        locked      <= 1'b0;
                        match_cnt_r <= 4'd0;
                        cnt_r       <= '0;
                        state_r     <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule
